rr_grant_arbiter: RTL

//   Round-robin arbiter over 32 request lines. Produces a registered 5-bit

---
 rtl/dec_pkg.sv | 16 +
 rtl/rr_grant_arbiter_if.sv | 33 +++
 rtl/rr_prio_enc.sv | 51 +++++
 rtl/rr_grant_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the round-robin arbiter and the downstream decoder stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dec_pkg;

    // Requester count and matching index width; the decoder stage uses the same values.
    localparam int DEC_N     = 32;
    localparam int DEC_IDX_W = 5;

    // IDLE: no grant outstanding. HOLD: grant_idx is valid and waiting for acceptance.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

endpackage : dec_pkg

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the grant consumer.
// Latency: n/a (wires only).
// Backpressure: grant_ready from the consumer holds the grant stable.
interface rr_grant_arbiter_if
    import dec_pkg::*;
#(
    parameter int N     = DEC_N,
    parameter int IDX_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic             grant_ready;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] ptr_dbg;

    // Arbiter side: consumes requests and ready, produces the grant.
    modport slave (
        input  req,
        input  grant_ready,
        output grant_valid,
        output grant_idx,
        output ptr_dbg
    );

    // Environment side: drives requests and ready, observes the grant.
    modport master (
        output req,
        output grant_ready,
        input  grant_valid,
        input  grant_idx,
        input  ptr_dbg
    );
endinterface : rr_grant_arbiter_if

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder: lowest set req bit at index >= ptr, else lowest set bit overall.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_prio_enc
    import dec_pkg::*;
#(
    parameter int N     = DEC_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0]     mask;
    logic [N-1:0]     req_masked;
    logic             m_found;
    logic [IDX_W-1:0] m_idx;
    logic [IDX_W-1:0] u_idx;

    // Bits at or above ptr take priority; the unmasked search covers the wrap.
    assign mask       = ~((N'(1) << ptr_i) - N'(1));
    assign req_masked = req_i & mask;

    // Find-first-set over the masked vector (upper part of the ring).
    always_comb begin
        m_found = 1'b0;
        m_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_masked[i]) begin
                m_found = 1'b1;
                m_idx   = IDX_W'(i);
            end
        end
    end

    // Find-first-set over the full vector, used when nothing sits at or above ptr.
    always_comb begin
        u_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                u_idx = IDX_W'(i);
            end
        end
    end

    assign found_o = |req_i;
    assign idx_o   = m_found ? m_idx : u_idx;

endmodule : rr_prio_enc

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter over N request lines with registered grant index and valid/ready handshake.
// Latency: request seen at edge k gives grant_valid after edge k; one grant per cycle back-to-back.
// Backpressure: grant_ready low freezes grant_idx and ptr; grants are never retracted.
module rr_grant_arbiter
    import dec_pkg::*;
#(
    parameter int N     = DEC_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    rr_grant_arbiter_if.slave  arb
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] ptr_next_acc;
    logic [IDX_W-1:0] enc_ptr;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;

    // Pointer that takes effect if the outstanding grant is accepted this cycle.
    assign ptr_next_acc = grant_idx_q + IDX_W'(1);

    // In HOLD the only winner that matters is the back-to-back one after acceptance,
    // so a single encoder is shared between the IDLE and HOLD searches.
    assign enc_ptr = (state_q == ARB_HOLD) ? ptr_next_acc : ptr_q;

    rr_prio_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req_i   (arb.req),
        .ptr_i   (enc_ptr),
        .found_o (win_found),
        .idx_o   (win_idx)
    );

    // Next-state logic: issue a grant from IDLE, advance on acceptance in HOLD.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_found) begin
                    grant_idx_d = win_idx;
                    state_d     = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (arb.grant_ready) begin
                    ptr_d = ptr_next_acc;
                    if (win_found) begin
                        grant_idx_d = win_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, grant and pointer registers; reset drops any pending grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_idx_q <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign arb.grant_valid = (state_q == ARB_HOLD);
    assign arb.grant_idx   = grant_idx_q;
    assign arb.ptr_dbg     = ptr_q;

endmodule : rr_grant_arbiter
